// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: per-requester result FIFOs drained round-robin into a registered CDB.
// Optional macro CDB_ARB_BYPASS_EN lets an empty requester win straight from its inputs.
module cdb_arbiter #(
  parameter int NUM_REQ         = 3,
  parameter int ROB_WIDTH_BIT   = 5,
  parameter int QUEUE_DEPTH_BIT = 1
) (
  input  logic                             clk_in,
  input  logic                             rst_in,
  input  logic                             rdy_in,
  input  logic                             clear_in,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ROB_WIDTH_BIT-1:0] req_id,
  input  logic [NUM_REQ*32-1:0]            req_val,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             cdb_valid,
  output logic [ROB_WIDTH_BIT-1:0]         cdb_id,
  output logic [31:0]                      cdb_val,
  output logic [1:0]                       cdb_src
);

  localparam int DEPTH = 1 << QUEUE_DEPTH_BIT;
  localparam logic [QUEUE_DEPTH_BIT:0] CNT_FULL = (QUEUE_DEPTH_BIT+1)'(DEPTH);
  localparam logic [1:0] LAST_REQ = 2'(NUM_REQ-1);

  logic [ROB_WIDTH_BIT-1:0]   r_q_id  [NUM_REQ][DEPTH];
  logic [31:0]                r_q_val [NUM_REQ][DEPTH];
  logic [QUEUE_DEPTH_BIT-1:0] r_head  [NUM_REQ];
  logic [QUEUE_DEPTH_BIT-1:0] r_tail  [NUM_REQ];
  logic [QUEUE_DEPTH_BIT:0]   r_count [NUM_REQ];
  logic [1:0]                 r_rr_ptr;
  logic                       r_cdb_valid;
  logic [ROB_WIDTH_BIT-1:0]   r_cdb_id;
  logic [31:0]                r_cdb_val;
  logic [1:0]                 r_cdb_src;

  logic [NUM_REQ-1:0]       w_cand;
  logic [NUM_REQ-1:0]       w_push;
  logic [NUM_REQ-1:0]       w_pop;
  logic                     w_grant;
  logic [1:0]               w_gnt_idx;
  logic                     w_bypass_win;
  logic [ROB_WIDTH_BIT-1:0] w_win_id;
  logic [31:0]              w_win_val;
  int                       w_idx;

  // Handshake: valid/ready transfer at a posedge when both are high; ready depends only on
  // registered occupancy and rdy_in, so a full FIFO never refills in the cycle it drains.
  always_comb begin
    w_cand       = '0;
    w_push       = '0;
    w_pop        = '0;
    w_grant      = 1'b0;
    w_gnt_idx    = 2'd0;
    w_bypass_win = 1'b0;
    w_win_id     = '0;
    w_win_val    = '0;
    w_idx        = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      req_ready[k] = rdy_in && (r_count[k] != CNT_FULL);
      w_cand[k]    = (r_count[k] != '0);
`ifdef CDB_ARB_BYPASS_EN
      if ((r_count[k] == '0) && req_valid[k] && req_ready[k]) w_cand[k] = 1'b1;
`endif
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = int'(r_rr_ptr) + i;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (!w_grant && w_cand[w_idx]) begin
        w_grant   = 1'b1;
        w_gnt_idx = 2'(w_idx);
      end
    end
    // An empty FIFO can only win through the bypass path.
    w_bypass_win = w_grant && (r_count[w_gnt_idx] == '0);
    if (w_bypass_win) begin
      w_win_id  = req_id[w_gnt_idx*ROB_WIDTH_BIT +: ROB_WIDTH_BIT];
      w_win_val = req_val[w_gnt_idx*32 +: 32];
    end else begin
      w_win_id  = r_q_id[w_gnt_idx][r_head[w_gnt_idx]];
      w_win_val = r_q_val[w_gnt_idx][r_head[w_gnt_idx]];
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      w_push[k] = req_valid[k] && req_ready[k] && !clear_in &&
                  !(w_bypass_win && (w_gnt_idx == 2'(k)));
      w_pop[k]  = rdy_in && !clear_in && w_grant && !w_bypass_win && (w_gnt_idx == 2'(k));
    end
  end

  always_ff @(posedge clk_in) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_push[k]) begin
        r_q_id[k][r_tail[k]]  <= req_id[k*ROB_WIDTH_BIT +: ROB_WIDTH_BIT];
        r_q_val[k][r_tail[k]] <= req_val[k*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        r_head[k]  <= '0;
        r_tail[k]  <= '0;
        r_count[k] <= '0;
      end
      r_rr_ptr    <= 2'd0;
      r_cdb_valid <= 1'b0;
      r_cdb_id    <= '0;
      r_cdb_val   <= '0;
      r_cdb_src   <= 2'd0;
    end else if (rdy_in) begin
      if (clear_in) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          r_head[k]  <= '0;
          r_tail[k]  <= '0;
          r_count[k] <= '0;
        end
        r_rr_ptr    <= 2'd0;
        r_cdb_valid <= 1'b0;
      end else begin
        for (int k = 0; k < NUM_REQ; k++) begin
          if (w_push[k]) r_tail[k] <= r_tail[k] + QUEUE_DEPTH_BIT'(1);
          if (w_pop[k])  r_head[k] <= r_head[k] + QUEUE_DEPTH_BIT'(1);
          r_count[k] <= r_count[k] + (QUEUE_DEPTH_BIT+1)'(w_push[k])
                                   - (QUEUE_DEPTH_BIT+1)'(w_pop[k]);
        end
        r_cdb_valid <= w_grant;
        if (w_grant) begin
          r_cdb_id  <= w_win_id;
          r_cdb_val <= w_win_val;
          r_cdb_src <= w_gnt_idx;
          r_rr_ptr  <= (w_gnt_idx == LAST_REQ) ? 2'd0 : w_gnt_idx + 2'd1;
        end
      end
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_id    = r_cdb_id;
  assign cdb_val   = r_cdb_val;
  assign cdb_src   = r_cdb_src;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus random traffic checked against a queue-based model.
module tb_cdb_arbiter;

  localparam int N     = 3;
  localparam int W     = 5;
  localparam int DEPTH = 2;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, rdy, clr;
  logic [N-1:0]     d_valid;
  logic [N*W-1:0]   d_ids;
  logic [N*32-1:0]  d_vals;
  logic [N-1:0]     req_ready;
  logic             cdb_valid;
  logic [W-1:0]     cdb_id;
  logic [31:0]      cdb_val;
  logic [1:0]       cdb_src;

  cdb_arbiter #(.NUM_REQ(N), .ROB_WIDTH_BIT(W), .QUEUE_DEPTH_BIT(1)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .clear_in(clr),
    .req_valid(d_valid), .req_id(d_ids), .req_val(d_vals), .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_id(cdb_id), .cdb_val(cdb_val), .cdb_src(cdb_src)
  );

  // scoreboard: one expected queue of {id, val} per requester
  logic [W+31:0] exp_q[N][$];
  int            m_rr;
  logic          m_valid;
  logic [W-1:0]  m_id;
  logic [31:0]   m_val;
  logic [1:0]    m_src;
  logic [N-1:0]  m_acc;
  int            n_vec = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // driver: one clock cycle with the current d_* vectors
  task automatic step(input logic i_rst, input logic i_rdy, input logic i_clr);
    logic [N-1:0]  m_ready;
    logic [W+31:0] e;
    int            g;
    logic          byp;
    @(negedge clk);
    rst = i_rst; rdy = i_rdy; clr = i_clr;
    #1;
    for (int k = 0; k < N; k++) m_ready[k] = i_rdy && (exp_q[k].size() < DEPTH);
    if (!i_rst) check("req_ready", 64'(req_ready), 64'(m_ready));
    m_acc = '0;
    if (i_rst) begin
      for (int k = 0; k < N; k++) exp_q[k].delete();
      m_rr = 0; m_valid = 0; m_id = '0; m_val = '0; m_src = '0;
    end else if (i_rdy) begin
      if (i_clr) begin
        for (int k = 0; k < N; k++) exp_q[k].delete();
        m_rr = 0; m_valid = 0;
      end else begin
        g = -1; byp = 0;
        for (int i = 0; i < N; i++) begin
          int k;
          k = (m_rr + i) % N;
          if (g < 0) begin
            if (exp_q[k].size() > 0) g = k;
`ifdef CDB_ARB_BYPASS_EN
            else if (d_valid[k] && m_ready[k]) begin g = k; byp = 1; end
`endif
          end
        end
        if (g >= 0) begin
          if (byp) e = {d_ids[g*W +: W], d_vals[g*32 +: 32]};
          else     e = exp_q[g].pop_front();
          m_valid = 1; m_id = e[W+31:32]; m_val = e[31:0]; m_src = 2'(g);
          m_rr = (g + 1) % N;
        end else begin
          m_valid = 0;
        end
        for (int k = 0; k < N; k++) begin
          if (d_valid[k] && m_ready[k]) begin
            m_acc[k] = 1'b1;
            if (!(byp && g == k)) exp_q[k].push_back({d_ids[k*W +: W], d_vals[k*32 +: 32]});
          end
        end
      end
    end
    @(posedge clk);
    #1;
    check("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    check("cdb_id",    64'(cdb_id),    64'(m_id));
    check("cdb_val",   64'(cdb_val),   64'(m_val));
    check("cdb_src",   64'(cdb_src),   64'(m_src));
  endtask

  task automatic set_req(input int k, input logic v, input logic [W-1:0] id, input logic [31:0] val);
    d_valid[k]       = v;
    d_ids[k*W +: W]  = id;
    d_vals[k*32 +: 32] = val;
  endtask

  task automatic idle();
    d_valid = '0;
  endtask

  initial begin
    int sent0;
    rst = 1; rdy = 1; clr = 0; d_valid = '0; d_ids = '0; d_vals = '0;
    step(1, 1, 0);
    step(1, 1, 0);
    check("reset_valid", 64'(cdb_valid), 64'd0);
    check("reset_id",    64'(cdb_id),    64'd0);

    // idle after reset
    idle();
    for (int c = 0; c < 10; c++) step(0, 1, 0);
    check("idle_ready", 64'(req_ready), 64'b111);

    // single push from requester 1
    set_req(1, 1, 5'd5, 32'hDEADBEEF);
    step(0, 1, 0);
    idle();
`ifndef CDB_ARB_BYPASS_EN
    check("single_pre", 64'(cdb_valid), 64'd0);
    step(0, 1, 0);
`endif
    check("single_valid", 64'(cdb_valid), 64'd1);
    check("single_id",    64'(cdb_id),    64'd5);
    check("single_val",   64'(cdb_val),   64'hDEADBEEF);
    check("single_src",   64'(cdb_src),   64'd1);
    step(0, 1, 0);
    check("single_gap", 64'(cdb_valid), 64'd0);

    // flush returns rr_ptr to 0, then all three push together
    step(0, 1, 1);
    for (int k = 0; k < N; k++) set_req(k, 1, 5'(k + 1), 32'h100 + k);
    step(0, 1, 0);
    idle();
    for (int c = 0; c < 4; c++) step(0, 1, 0);

    // requester 0 streams 7,8,9 against a continuously busy requester 2
    sent0 = 0;
    for (int c = 0; c < 20 && sent0 < 3; c++) begin
      set_req(0, 1, 5'(7 + sent0), 32'h7000 + sent0);
      set_req(2, 1, 5'($urandom_range(20, 31)), $urandom);
      step(0, 1, 0);
      if (m_acc[0]) sent0++;
    end
    check("r0_sent", 64'(sent0), 64'd3);
    idle();
    for (int c = 0; c < 6; c++) step(0, 1, 0);

    // fill several FIFOs, then flush; nothing pre-flush may appear afterwards
    for (int c = 0; c < 2; c++) begin
      for (int k = 0; k < N; k++) set_req(k, 1, 5'(20 + 3*c + k), $urandom);
      step(0, 1, 0);
    end
    idle();
    step(0, 1, 1);
    check("flush_valid", 64'(cdb_valid), 64'd0);
    for (int c = 0; c < 3; c++) step(0, 1, 0);
    check("flush_ready", 64'(req_ready), 64'b111);

    // pause with entries pending
    for (int k = 0; k < N; k++) set_req(k, 1, 5'(10 + k), $urandom);
    step(0, 1, 0);
    idle();
    for (int c = 0; c < 5; c++) step(0, 0, $urandom_range(0, 1) == 1);
    check("pause_ready", 64'(req_ready), 64'd0);
    for (int c = 0; c < 4; c++) step(0, 1, 0);

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      for (int k = 0; k < N; k++)
        set_req(k, $urandom_range(0, 99) < 45, 5'($urandom), $urandom);
      step($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0);
    end
    idle();
    for (int c = 0; c < 8; c++) step(0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the ROB's single result-write (common data bus) port between NUM_REQ execution units (ALU RS, LSB, branch unit, ...).
- Each requester pushes (rob_id, value) into its own small FIFO.
- A round-robin arbiter pops one head per cycle into a registered CDB output that drives the ROB set port and the RS/LSB wakeup logic.
- A mispredict clear from the ROB flushes all pending results.

Parameters:
- NUM_REQ, 3, number of requesting units (2..4).
- ROB_WIDTH_BIT, 5, width of a ROB index.
- QUEUE_DEPTH_BIT, 1, log2 of per-requester FIFO depth (default depth 2).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous active-high reset.
- rdy_in  input  1  global ready; low pauses the block.
- clear_in  input  1  ROB mispredict flush (ROB clear_flag).
- req_valid  input  NUM_REQ  per-requester result valid.
- req_id  input  NUM_REQ*ROB_WIDTH_BIT  packed ROB indices; requester k uses bits [k*ROB_WIDTH_BIT +: ROB_WIDTH_BIT].
- req_val  input  NUM_REQ*32  packed result values; requester k uses bits [k*32 +: 32].
- req_ready  output  NUM_REQ  per-requester accept; high = FIFO can take an entry.
- cdb_valid  output  1  broadcast valid (registered).
- cdb_id  output  ROB_WIDTH_BIT  broadcast ROB index (registered).
- cdb_val  output  32  broadcast value (registered).
- cdb_src  output  2  index of the granted requester (registered).

Behaviour:
- Reset: when rst_in=1 at a posedge:
  - all FIFOs are emptied (head, tail and count go to 0);
  - rr_ptr is set to 0;
  - cdb_valid, cdb_id, cdb_val and cdb_src are set to 0.
  - rst_in has priority over every other input.
- Handshake:
  - req_ready[k] = rdy_in && (count[k] != depth). It is combinational from registered state only and never depends on req_valid.
  - An entry is pushed at the posedge where req_valid[k] && req_ready[k] && !clear_in.
  - A full FIFO deasserts req_ready even if the same cycle pops it. There is no same-cycle refill.
- Arbitration (every posedge with rdy_in=1 and clear_in=0):
  - Candidate set = requesters whose FIFO is non-empty, evaluated before this cycle's pushes.
  - Search order: rr_ptr, rr_ptr+1, ... mod NUM_REQ. The first candidate found is the grant g.
  - On a grant: pop FIFO g; cdb_valid<=1; cdb_id, cdb_val <= head entry of g; cdb_src<=g; rr_ptr <= (g+1) mod NUM_REQ.
  - No candidate: cdb_valid<=0. cdb_id, cdb_val and cdb_src hold. rr_ptr holds.
  - cdb_valid is a one-cycle pulse per grant. Back-to-back grants give continuous cdb_valid.
- Latency: a push at edge N is broadcast at edge N+1 at the earliest (visible during cycle N+1). Delay beyond that comes only from contention.
- Ordering: results from the same requester are broadcast in push order. Results from different requesters have no ordering guarantee.
- FIFO: circular buffer with pointers of QUEUE_DEPTH_BIT bits that wrap naturally, plus a count of QUEUE_DEPTH_BIT+1 bits. Simultaneous push and pop on a non-full FIFO keeps count unchanged.
- Flush: clear_in=1 with rdy_in=1 at a posedge:
  - all FIFOs are emptied and same-cycle pushes are discarded;
  - cdb_valid<=0 and rr_ptr<=0.
  - clear_in while rdy_in=0 is ignored.
- Pause: rdy_in=0 freezes all registers, including cdb_valid. req_ready is 0. Consumers sample the CDB only when rdy_in=1.
- Requester id collisions are not checked. The ROB guarantees that live ids are unique.

Optional Feature:
- Macro: CDB_ARB_BYPASS_EN.
- Defined:
  - A requester whose FIFO is empty and which presents req_valid with req_ready high also joins the candidate set that cycle.
  - If it wins, its input goes straight to the cdb registers at edge N (zero queue latency) and is not pushed.
  - If it loses, it is pushed normally.
  - Round-robin order is unchanged.
- Undefined: every result passes through its FIFO, with 1-cycle minimum latency as specified above.

Test Plan:
- Reset, then idle -> cdb_valid=0 and req_ready=3'b111 for 10 cycles.
- Single push, requester 1, id=5, val=0xDEADBEEF at edge N -> at edge N+1: cdb_valid=1, cdb_id=5, cdb_val=0xDEADBEEF, cdb_src=1. Edge N+2: cdb_valid=0. (With bypass: broadcast at edge N.)
- All 3 requesters push in the same cycle (ids 1, 2, 3) with rr_ptr=0 -> broadcast order src 0, 1, 2 on 3 consecutive cycles. rr_ptr ends at 0.
- Requester 0 pushes ids 7, 8, 9 back-to-back while requester 2 pushes continuously -> req_ready[0] drops after 2 entries. Broadcasts alternate src 0/2. Requester 0's ids come out in order 7, 8, 9.
- FIFOs holding 4 entries, clear_in=1 for one cycle -> next cycle: cdb_valid=0 and all req_ready=1. No pre-flush id is ever broadcast.
- rdy_in=0 for 5 cycles with entries pending -> outputs frozen and req_ready=0. After rdy_in returns to 1, broadcasts resume in the same round-robin order.
